// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch-side types for the instruction queue.
//   decode_info_t : decoder summary carried with each fetched instruction
//   bpu_predict_t : branch prediction already fixed up upstream
//   iq_entry_t    : one queue entry {pc, decode, predict}
package fetch_inst_queue_pkg;

  localparam int unsigned IQ_PC_W = 32;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic       is_branch;
  } decode_info_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } bpu_predict_t;

  typedef struct packed {
    logic [IQ_PC_W-1:0] pc;
    decode_info_t       decode;
    bpu_predict_t       predict;
  } iq_entry_t;

endpackage

// File: rtl/fetch_iq_ptr.sv
// Head/tail/count bookkeeping for fetch_inst_queue.
//   clk, rst_n : clock, async active-low reset
//   flush_i    : clears all pointers next cycle, overrides push/pop
//   push_i     : per-slot accepted writes (already gated by ready_o)
//   pop_i      : per-slot consume requests
//   head_o     : oldest entry index
//   tail_o     : next free index
//   count_o    : occupancy, 0..DEPTH
//   ready_o    : room for two more entries (from registered count)
module fetch_iq_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [1:0]       push_i,
  input  logic [1:0]       pop_i,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic [PTR_W:0]   count_o,
  output logic             ready_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   nw, np, np_eff;

  always_comb begin
    nw      = (PTR_W+1)'(push_i[0]) + (PTR_W+1)'(push_i[1]);
    np      = (PTR_W+1)'(pop_i[0]) + (PTR_W+1)'(pop_i[1]);
    // Over-pop is illegal; clamp so an empty queue simply ignores pop_i.
    np_eff  = (np > count_q) ? count_q : np;
    head_d  = head_q + np_eff[PTR_W-1:0];
    tail_d  = tail_q + nw[PTR_W-1:0];
    count_d = count_q + nw - np_eff;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign ready_o = (count_q <= (PTR_W+1)'(DEPTH - 2));

endmodule

// File: rtl/fetch_inst_queue.sv
// Dual-write / dual-read instruction queue behind the branch fixup stage.
// Compacts up to two writes per cycle in program order and presents the two
// oldest entries to decode.
//   clk, rst_n             : clock, async active-low reset
//   flush_i                : backend redirect, empties the queue
//   wvalid_i/wpc_i/wdecode_i/wpredict_i : two write slots from fixup
//   ready_o                : queue can take two entries this cycle
//   rvalid_o/rpc_o/rdecode_o/rpredict_o : head and head+1 entries
//   pop_i                  : consume head entries (pop_i[1] only with pop_i[0])
module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [1:0]              wvalid_i,
  input  logic [1:0][31:0]        wpc_i,
  input  decode_info_t [1:0]      wdecode_i,
  input  bpu_predict_t [1:0]      wpredict_i,
  output logic                    ready_o,
  output logic [1:0]              rvalid_o,
  output logic [1:0][31:0]        rpc_o,
  output decode_info_t [1:0]      rdecode_o,
  output bpu_predict_t [1:0]      rpredict_o,
  input  logic [1:0]              pop_i
);

  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        slot0, slot1, first;
  iq_entry_t        rd0, rd1;
  logic [1:0]       push;
  logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
  logic [PTR_W:0]   count;

  assign slot0 = '{pc: wpc_i[0], decode: wdecode_i[0], predict: wpredict_i[0]};
  assign slot1 = '{pc: wpc_i[1], decode: wdecode_i[1], predict: wpredict_i[1]};
  // Lowest valid slot always lands at tail, so {0,1} writes slot1 there.
  assign first = wvalid_i[0] ? slot0 : slot1;
  assign push  = wvalid_i & {2{ready_o & ~flush_i}};

  fetch_iq_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop_i),
    .head_o  (head),
    .tail_o  (tail),
    .count_o (count),
    .ready_o (ready_o)
  );

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push != 2'b00) mem_q[tail]    <= first;
      if (push == 2'b11) mem_q[tail_p1] <= slot1;
    end
  end

  assign rd0 = mem_q[head];
  assign rd1 = mem_q[head_p1];

  assign rvalid_o      = {count >= (PTR_W+1)'(2), count >= (PTR_W+1)'(1)};
  assign rpc_o[0]      = rd0.pc;
  assign rpc_o[1]      = rd1.pc;
  assign rdecode_o[0]  = rd0.decode;
  assign rdecode_o[1]  = rd1.decode;
  assign rpredict_o[0] = rd0.predict;
  assign rpredict_o[1] = rd1.predict;

  a_pop_order : assert property (@(posedge clk) disable iff (!rst_n) pop_i != 2'b10);
  a_count_max : assert property (@(posedge clk) disable iff (!rst_n) count <= (PTR_W+1)'(DEPTH));
  a_no_ovfl   : assert property (@(posedge clk) disable iff (!rst_n) !ready_o |-> wvalid_i == 2'b00);

endmodule
